scan_link_receiver: RTL and testbench
=====================================

SCAN_LINK_RECEIVER -- requirements
Module: scan_link_receiver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, idle clk cycles without a serial edge before an in-progress frame is aborted.
REQ-002 SHALL have ports, one per line: name direction width meaning.
  clk  input  1  system clock; all state on posedge.
  rst  input  1  asynchronous, active-high reset.
  serialClkIn  input  1  serial link clock from scanner; asynchronous to clk.
  serialDataIn  input  1  serial link data; valid at serialClkIn rising edge.
  dataReady  input  1  consumer accepts dataByte this cycle.
  readyToTransferCmd  output  1  one-cycle pulse: command 8'd2 received.
  startScanningCmd  output  1  one-cycle pulse: command 8'd3 received.
  bufferFullCmd  output  1  one-cycle pulse: command 8'd4 received.
  dataByte  output  8  last received data byte.
  dataValid  output  1  dataByte holds an unaccepted byte.
  badCommand  output  1  one-cycle pulse: undefined command code received.
  frameError  output  1  one-cycle pulse: partial frame aborted by timeout.
  overflow  output  1  sticky: data byte dropped because previous was unaccepted.
  ps  output  2  current state, for debug.

Function
REQ-003 SHALL pass serialClkIn and serialDataIn each through a 2-flop synchronizer on clk.
REQ-004 SHALL detect a link edge when synchronized clock is 1 and its previous registered value is 0; the synchronized data bit is sampled in that same cycle.
REQ-005 SHALL assemble frames as 8 bits, LSB first: the k-th sampled bit of a frame (k = 0..7) is bit k of the frame.
REQ-006 SHALL hold a 3-bit bit counter that increments on each edge and wraps 7->0; wrap marks frame completion.
REQ-007 SHALL implement states HUNT=2'b00, CMD=2'b01, DATA=2'b10; 2'b11 is unused and returns to HUNT on the next cycle.
REQ-008 HUNT: bit counter is 0; the first edge samples bit 0 and moves to CMD.
REQ-009 CMD, on frame completion: 2/3/4 -> pulse the matching *Cmd output, go to HUNT; 7 -> go to DATA with no pulse; any other value -> pulse badCommand, go to HUNT.
REQ-010 DATA: the next 8 edges form the data byte; on completion, deliver the byte per REQ-012 and go to HUNT.
REQ-011 All pulses and dataValid updates SHALL be registered and assert in the clk cycle after the cycle in which the 8th edge is detected; pulses are exactly one cycle long.
REQ-012 Delivery: if dataValid=0, or dataValid=1 with dataReady=1 in the same cycle, load dataByte and set dataValid=1.
REQ-012a Delivery otherwise: keep the old dataByte, drop the new byte and set overflow.
REQ-013 dataValid SHALL clear in the cycle after dataValid & dataReady, unless a new byte loads in that cycle.
REQ-014 dataByte SHALL change only on load.
REQ-015 In CMD or DATA, an idle counter SHALL count clk cycles since the last edge.
REQ-015a When the idle counter reaches TIMEOUT: pulse frameError, discard partial bits, reset bit counter and idle counter to 0, go to HUNT.
REQ-015b The idle counter SHALL be held at 0 in HUNT.
REQ-016 An edge arriving in the same cycle the timeout fires SHALL be ignored (timeout wins).
REQ-017 overflow SHALL clear only on rst.
REQ-018 dataReady while dataValid=0 SHALL have no effect.

Reset
REQ-019 While rst=1, asynchronously: ps=HUNT; bit counter, idle counter, shift register and synchronizers = 0.
REQ-019a While rst=1, asynchronously: dataByte=8'h00; dataValid, overflow and all pulse outputs = 0.
REQ-020 Reset asserted mid-frame SHALL discard the frame with no pulse or frameError after release.
REQ-021 After release, the first edge SHALL be treated as bit 0 of a command frame.

Verification
REQ-022 Send frame 8'd3 LSB first, edges 8 clk apart -> startScanningCmd pulses exactly 1 cycle, 1 cycle after the 8th edge is detected; ps returns to 2'b00.
REQ-023 Send 8'd7 then 8'hA5 back to back, dataReady=0 -> dataByte=8'hA5, dataValid=1 held; no *Cmd pulse.
REQ-023a Then assert dataReady for 1 cycle -> dataValid=0 on the next cycle.
REQ-024 Send 8'd7,8'h11, hold dataReady=0, then send 8'd7,8'h22 -> overflow=1, dataByte stays 8'h11.
REQ-024a Repeat with dataReady=1 in the completion cycle -> dataByte=8'h22, overflow=0.
REQ-025 Send 5 bits, then stop edges for TIMEOUT cycles -> frameError pulses once, ps=HUNT; a following 8'd2 frame -> readyToTransferCmd pulses.
REQ-026 Send 8'd9 -> badCommand pulses, no other output changes.
REQ-026a Assert rst after 4 bits of 8'd4 -> all outputs 0 immediately; a full 8'd4 after release -> bufferFullCmd pulses.

Source files
------------

// File: rtl/scan_link_receiver.sv
// Serial scanner link receiver: synchronizes the scanner clock/data, assembles
// LSB-first bytes, decodes command frames and hands data bytes to a consumer.
module scan_link_receiver #(
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serialClkIn,
  input  logic       serialDataIn,
  input  logic       dataReady,
  output logic       readyToTransferCmd,
  output logic       startScanningCmd,
  output logic       bufferFullCmd,
  output logic [7:0] dataByte,
  output logic       dataValid,
  output logic       badCommand,
  output logic       frameError,
  output logic       overflow,
  output logic [1:0] ps
);

  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'b00,
    CMD    = 2'b01,
    DATA   = 2'b10,
    UNUSED = 2'b11
  } state_t;

  state_t          state, state_nx;
  logic            sclk_meta, sclk_sync, sclk_prev;
  logic            sdat_meta, sdat_sync;
  logic [2:0]      bit_cnt, bit_cnt_nx;
  logic [7:0]      shift, shift_nx;
  logic [IW-1:0]   idle, idle_nx;
  logic            link_edge, timeout;
  logic [7:0]      frame;
  logic            ready_nx, start_nx, full_nx, bad_nx, ferr_nx;
  logic            load, drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_prev <= 1'b0;
      sdat_meta <= 1'b0;
      sdat_sync <= 1'b0;
    end else begin
      sclk_meta <= serialClkIn;
      sclk_sync <= sclk_meta;
      sclk_prev <= sclk_sync;
      sdat_meta <= serialDataIn;
      sdat_sync <= sdat_meta;
    end
  end

  // New bit enters at the MSB so that after eight edges bit 0 sits at the LSB.
  assign link_edge = sclk_sync & ~sclk_prev;
  assign frame     = {sdat_sync, shift[7:1]};
  assign timeout   = ((state == CMD) || (state == DATA)) && (idle == IW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
      idle    <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      shift   <= shift_nx;
      idle    <= idle_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shift_nx   = shift;
    idle_nx    = idle;
    ready_nx   = 1'b0;
    start_nx   = 1'b0;
    full_nx    = 1'b0;
    bad_nx     = 1'b0;
    ferr_nx    = 1'b0;
    load       = 1'b0;
    drop       = 1'b0;
    case (state)
      HUNT: begin
        idle_nx = '0;
        if (link_edge) begin
          shift_nx   = frame;
          bit_cnt_nx = bit_cnt + 3'd1;
          state_nx   = CMD;
        end
      end
      CMD, DATA: begin
        // A timeout takes priority over an edge landing in the same cycle.
        if (timeout) begin
          ferr_nx    = 1'b1;
          state_nx   = HUNT;
          bit_cnt_nx = 3'd0;
          idle_nx    = '0;
          shift_nx   = 8'h00;
        end else if (link_edge) begin
          idle_nx    = '0;
          shift_nx   = frame;
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_nx = HUNT;
            if (state == CMD) begin
              case (frame)
                8'd2:    ready_nx = 1'b1;
                8'd3:    start_nx = 1'b1;
                8'd4:    full_nx  = 1'b1;
                8'd7:    state_nx = DATA;
                default: bad_nx   = 1'b1;
              endcase
            end else if (!dataValid || dataReady) begin
              load = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
        end else begin
          idle_nx = idle + IW'(1);
        end
      end
      default: begin
        state_nx   = HUNT;
        bit_cnt_nx = 3'd0;
        idle_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readyToTransferCmd <= 1'b0;
      startScanningCmd   <= 1'b0;
      bufferFullCmd      <= 1'b0;
      badCommand         <= 1'b0;
      frameError         <= 1'b0;
      dataByte           <= 8'h00;
      dataValid          <= 1'b0;
      overflow           <= 1'b0;
    end else begin
      readyToTransferCmd <= ready_nx;
      startScanningCmd   <= start_nx;
      bufferFullCmd      <= full_nx;
      badCommand         <= bad_nx;
      frameError         <= ferr_nx;
      if (load) begin
        dataByte  <= frame;
        dataValid <= 1'b1;
      end else if (dataValid && dataReady) begin
        dataValid <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  assign ps = state;

endmodule

// File: tb/tb_scan_link_receiver.sv
// Directed bench for scan_link_receiver with a frame-level reference model
// checked every cycle plus hand-computed expectations.
module tb_scan_link_receiver;

  localparam int TIMEOUT = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclk = 1'b0;
  logic       sdat = 1'b0;
  logic       ready = 1'b0;
  logic       o_rdy, o_start, o_full, o_valid, o_bad, o_ferr, o_ovf;
  logic [7:0] o_byte;
  logic [1:0] o_ps;

  int errors = 0;
  int checks = 0;

  scan_link_receiver #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .serialClkIn(sclk), .serialDataIn(sdat),
    .dataReady(ready), .readyToTransferCmd(o_rdy), .startScanningCmd(o_start),
    .bufferFullCmd(o_full), .dataByte(o_byte), .dataValid(o_valid),
    .badCommand(o_bad), .frameError(o_ferr), .overflow(o_ovf), .ps(o_ps)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each driven serial rise is stamped with the clk cycle in
  // which its effect becomes visible (two synchronizer flops plus one register).
  int         cyc = 0;
  int         qt[$];
  logic       qb[$];
  int         m_mode = 0;
  int         m_n = 0;
  int         last_edge = 0;
  logic [7:0] m_frame = 8'h00;
  logic [7:0] m_byte = 8'h00;
  logic       m_valid = 1'b0, m_ovf = 1'b0;
  logic       m_rdy = 1'b0, m_start = 1'b0, m_full = 1'b0, m_bad = 1'b0, m_ferr = 1'b0;

  initial begin
    logic ev, evb, old_valid, rd;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_mode = 0; m_n = 0; m_byte = 8'h00; m_valid = 0; m_ovf = 0;
        m_rdy = 0; m_start = 0; m_full = 0; m_bad = 0; m_ferr = 0;
        qt.delete(); qb.delete();
      end else begin
        cyc++;
        ev = 1'b0; evb = 1'b0;
        if (qt.size() > 0 && qt[0] == cyc) begin
          ev = 1'b1; evb = qb[0];
          void'(qt.pop_front()); void'(qb.pop_front());
        end
        old_valid = m_valid; rd = ready;
        m_rdy = 0; m_start = 0; m_full = 0; m_bad = 0; m_ferr = 0;
        if (old_valid && rd) m_valid = 1'b0;
        if (m_mode != 0 && (cyc - last_edge) == TIMEOUT + 1) begin
          m_ferr = 1; m_mode = 0; m_n = 0;
        end else if (ev) begin
          last_edge = cyc;
          m_frame[m_n] = evb;
          m_n++;
          if (m_mode == 0) m_mode = 1;
          else if (m_n == 8) begin
            m_n = 0;
            if (m_mode == 1) begin
              m_mode = 0;
              if (m_frame == 8'd2) m_rdy = 1;
              else if (m_frame == 8'd3) m_start = 1;
              else if (m_frame == 8'd4) m_full = 1;
              else if (m_frame == 8'd7) m_mode = 2;
              else m_bad = 1;
            end else begin
              m_mode = 0;
              if (!old_valid || rd) begin m_byte = m_frame; m_valid = 1; end
              else m_ovf = 1;
            end
          end
        end
      end
    end
  end

  int n_rdy = 0, n_start = 0, n_full = 0, n_bad = 0, n_ferr = 0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("readyToTransferCmd", o_rdy, m_rdy);
      chk("startScanningCmd", o_start, m_start);
      chk("bufferFullCmd", o_full, m_full);
      chk("badCommand", o_bad, m_bad);
      chk("frameError", o_ferr, m_ferr);
      chk("dataValid", o_valid, m_valid);
      chk("dataByte", o_byte, m_byte);
      chk("overflow", o_ovf, m_ovf);
      chk("ps", o_ps, m_mode);
      n_rdy += int'(o_rdy); n_start += int'(o_start); n_full += int'(o_full);
      n_bad += int'(o_bad); n_ferr += int'(o_ferr);
    end
  end

  task automatic send_bit(input logic b, input logic ready_pulse);
    @(negedge clk); sclk = 1'b0; sdat = b;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    qt.push_back(cyc + 3); qb.push_back(b);
    if (ready_pulse) begin
      repeat (2) @(negedge clk);
      ready = 1'b1;
      @(negedge clk); ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ready_last);
    for (int i = 0; i < 8; i++) send_bit(v[i], ready_last && (i == 7));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte"}, o_byte, 8'h00);
    chk({tag, "_valid"}, o_valid, 1'b0);
    chk({tag, "_ovf"}, o_ovf, 1'b0);
    chk({tag, "_ps"}, o_ps, 2'b00);
    chk({tag, "_pulses"}, {o_rdy, o_start, o_full, o_bad, o_ferr}, 5'b0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk); #2;
    rst = 1'b1; sclk = 1'b0; ready = 1'b0;
    #1 chk_all_zero(tag);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int b_rdy, b_start, b_full, b_bad, b_ferr;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);

    b_start = n_start; b_rdy = n_rdy; b_full = n_full; b_bad = n_bad;
    send_byte(8'd3, 1'b0);
    repeat (6) @(negedge clk);
    chk("start_once", n_start - b_start, 1);
    chk("start_others", (n_rdy - b_rdy) + (n_full - b_full) + (n_bad - b_bad), 0);
    chk("start_ps", o_ps, 2'b00);

    b_start = n_start; b_rdy = n_rdy; b_full = n_full; b_bad = n_bad;
    send_byte(8'd7, 1'b0);
    send_byte(8'hA5, 1'b0);
    repeat (10) @(negedge clk);
    chk("a5_byte", o_byte, 8'hA5);
    chk("a5_valid", o_valid, 1'b1);
    chk("a5_nocmd", (n_start - b_start) + (n_rdy - b_rdy) + (n_full - b_full) + (n_bad - b_bad), 0);
    ready = 1'b1;
    @(negedge clk); ready = 1'b0;
    chk("a5_cleared", o_valid, 1'b0);
    chk("a5_byte_kept", o_byte, 8'hA5);

    do_reset("rst1");
    send_byte(8'd7, 1'b0); send_byte(8'h11, 1'b0);
    repeat (6) @(negedge clk);
    send_byte(8'd7, 1'b0); send_byte(8'h22, 1'b0);
    repeat (6) @(negedge clk);
    chk("ovf_set", o_ovf, 1'b1);
    chk("ovf_byte", o_byte, 8'h11);
    chk("ovf_valid", o_valid, 1'b1);

    do_reset("rst2");
    send_byte(8'd7, 1'b0); send_byte(8'h11, 1'b0);
    repeat (6) @(negedge clk);
    send_byte(8'd7, 1'b0); send_byte(8'h22, 1'b1);
    repeat (6) @(negedge clk);
    chk("take_byte", o_byte, 8'h22);
    chk("take_ovf", o_ovf, 1'b0);
    chk("take_valid", o_valid, 1'b1);

    b_ferr = n_ferr; b_rdy = n_rdy;
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
    repeat (TIMEOUT + 10) @(negedge clk);
    chk("tmo_ferr", n_ferr - b_ferr, 1);
    chk("tmo_ps", o_ps, 2'b00);
    send_byte(8'd2, 1'b0);
    repeat (6) @(negedge clk);
    chk("tmo_next_cmd", n_rdy - b_rdy, 1);

    b_bad = n_bad; b_start = n_start; b_rdy = n_rdy; b_full = n_full; b_ferr = n_ferr;
    send_byte(8'd9, 1'b0);
    repeat (6) @(negedge clk);
    chk("bad_once", n_bad - b_bad, 1);
    chk("bad_others", (n_start - b_start) + (n_rdy - b_rdy) + (n_full - b_full) + (n_ferr - b_ferr), 0);
    chk("bad_byte", o_byte, 8'h22);
    chk("bad_valid", o_valid, 1'b1);

    for (int i = 0; i < 4; i++) send_bit(i == 2, 1'b0);
    repeat (6) @(negedge clk);
    do_reset("rst_mid");
    b_full = n_full; b_ferr = n_ferr;
    send_byte(8'd4, 1'b0);
    repeat (TIMEOUT + 6) @(negedge clk);
    chk("full_once", n_full - b_full, 1);
    chk("full_no_ferr", n_ferr - b_ferr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
